fetch_stage: RTL

//  Instruction fetch stage of the RISC-V core; sits directly upstream of decoder.
//  - Holds the PC and issues one instruction-memory read at a time.
//  - Buffers returned words with their PC in a small FIFO.
//  - Presents {instr, pc} to decode with a valid/ready handshake.
//  - Handles redirects (taken branch/jump) from later stages by flushing.

---
 rtl/fetch_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
// Instruction fetch stage: one outstanding imem read at a time, small {instr, pc} buffer
// toward decode, and flush/restart on redirects from later stages.
module fetch_stage #(
  parameter logic [`WORD_SIZE-1:0] RESET_PC   = `WORD_SIZE'('h200),
  parameter int unsigned           FIFO_DEPTH = 2,
  parameter logic [`WORD_SIZE-1:0] NOP_INSTR  = `WORD_SIZE'('h00000013)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  output logic [`WORD_SIZE-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [`WORD_SIZE-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [`WORD_SIZE-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [`WORD_SIZE-1:0] instr,
  output logic [`WORD_SIZE-1:0] pc,
  input  logic                  dec_ready
);

  localparam int unsigned W    = `WORD_SIZE;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StReq, StWait, StDrain} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [W-1:0]    req_pc_q;
  logic [W-1:0]    last_pc_q;
  logic [W-1:0]    fifo_instr_q [FIFO_DEPTH];
  logic [W-1:0]    fifo_pc_q    [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic         has_space, fifo_empty, req_fire, push, pop;
  logic [W-1:0] redirect_target;

  always_comb begin
    has_space       = count_q < CntW'(FIFO_DEPTH);
    fifo_empty      = count_q == '0;
    imem_req_valid  = !reset && (state_q == StReq) && has_space;
    imem_req_addr   = fetch_pc_q;
    req_fire        = imem_req_valid && imem_req_ready;
    // A response landing during a redirect belongs to the squashed path.
    push            = (state_q == StWait) && imem_resp_valid && !redirect_valid;
    instr_valid     = !reset && !fifo_empty;
    pop             = instr_valid && dec_ready && !redirect_valid;
    redirect_target = redirect_pc & ~W'(3);
    instr           = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
    if (reset) begin
      pc = RESET_PC;
    end else if (fifo_empty) begin
      pc = last_pc_q;
    end else begin
      pc = fifo_pc_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + W'(4);
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
    end
    case (state_q)
      StReq: begin
        // A request accepted alongside a redirect is stale but still outstanding.
        if (req_fire) begin
          state_d = redirect_valid ? StDrain : StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end else if (redirect_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      last_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (req_fire) begin
        req_pc_q <= fetch_pc_q;
      end
      if (!fifo_empty) begin
        last_pc_q <= fifo_pc_q[rd_ptr_q];
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_instr_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule
